// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM fade engine:
// mode codes and sequencer state encodings.
package pwm_fade_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STATIC  = 2'd1;
  localparam logic [1:0] MODE_RAINBOW = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic {
    RAMP = 1'b0,
    HOLD = 1'b1
  } seq_state_t;

endpackage

// File: rtl/tick_div.sv
// Free-running prescaler: one-cycle pulse every DIV
// enabled cycles, frozen while en is low.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/pwm_fade_engine.sv
// Multi-channel PWM with per-channel level fading
// toward mode-selected targets and a sequencing FSM.
module pwm_fade_engine
  import pwm_fade_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int PWM_BITS   = 8,
  parameter int PWM_DIV    = 100,
  parameter int FADE_DIV   = 20000,
  parameter int FADE_STEP  = 1,
  parameter int HOLD_STEPS = 0,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic [1:0]                   MODE,
  input  logic                         WR_EN,
  input  logic [CW-1:0]                WR_CH,
  input  logic [PWM_BITS-1:0]          WR_DATA,
  output logic [NUM_CH-1:0]            PWM_OUT,
  output logic [NUM_CH*PWM_BITS-1:0]   LEVEL,
  output logic                         SETTLED,
  output logic                         PERIOD_START
);

  localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [HW-1:0] HOLD_N = HW'(HOLD_STEPS);
  localparam logic [PWM_BITS-1:0] LMAX = '1;
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS + 1)'(FADE_STEP);

  logic pwm_tick;
  logic fade_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_CH-1:0] cmp;
  logic [NUM_CH-1:0] at_tgt;
  logic [NUM_CH-1:0] step_at_tgt;
  logic [NUM_CH-1:0] johnson;
  logic [NUM_CH-1:0] johnson_nxt;
  logic phase_up;
  logic [1:0] mode_q;
  logic mode_chg;
  logic [HW-1:0] hold_cnt;
  seq_state_t state;
  seq_state_t state_nxt;
  logic hold_load;
  logic hold_dec;
  logic advance;

  tick_div #(.DIV(PWM_DIV)) u_pwm_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (EN),
    .tick (pwm_tick)
  );

  tick_div #(.DIV(FADE_DIV)) u_fade_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (EN),
    .tick (fade_tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt      <= '0;
      PERIOD_START <= 1'b0;
    end else begin
      PERIOD_START <= pwm_tick && (pwm_cnt == LMAX);
      if (pwm_tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PWM_OUT <= '0;
    end else if (!EN) begin
      PWM_OUT <= '0;
    end else if (pwm_tick) begin
      PWM_OUT <= cmp;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CW:0] IDX = (CW + 1)'(i);

    logic [PWM_BITS-1:0] lv;
    logic [PWM_BITS-1:0] hr;
    logic [PWM_BITS-1:0] tg;
    logic [PWM_BITS-1:0] nx;
    logic [PWM_BITS:0] up;
    logic [PWM_BITS:0] dn;

    always_comb begin
      unique case (1'b1)
        MODE == MODE_STATIC:  tg = hr;
        MODE == MODE_RAINBOW: tg = johnson[i] ? LMAX : '0;
        MODE == MODE_BREATHE: tg = phase_up ? hr : '0;
        default:              tg = '0;
      endcase
    end

    // one extra bit so the step can neither wrap nor overshoot
    assign up = {1'b0, lv} + STEP;
    assign dn = {1'b0, lv} - STEP;

    always_comb begin
      nx = lv;
      if (tg > lv) begin
        nx = (up > {1'b0, tg}) ? tg : up[PWM_BITS-1:0];
      end else if (tg < lv) begin
        nx = (dn[PWM_BITS] || dn < {1'b0, tg}) ? tg : dn[PWM_BITS-1:0];
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        lv <= '0;
        hr <= '0;
      end else begin
        if (WR_EN && {1'b0, WR_CH} == IDX) hr <= WR_DATA;
        if (fade_tick) lv <= nx;
      end
    end

    assign LEVEL[i*PWM_BITS +: PWM_BITS] = lv;
    assign cmp[i]         = pwm_cnt < lv;
    assign at_tgt[i]      = lv == tg;
    assign step_at_tgt[i] = nx == tg;
  end

  assign SETTLED  = &at_tgt;
  assign mode_chg = MODE != mode_q;

  always_comb begin
    johnson_nxt    = johnson << 1;
    johnson_nxt[0] = ~johnson[NUM_CH-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RAMP;
    end else if (mode_chg) begin
      state <= RAMP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RAMP: if (fade_tick && &step_at_tgt) state_nxt = HOLD;
      HOLD: if (fade_tick && hold_cnt == '0) state_nxt = RAMP;
      default: state_nxt = RAMP;
    endcase
  end

  always_comb begin
    hold_load = (state == RAMP) && fade_tick && &step_at_tgt;
    hold_dec  = (state == HOLD) && fade_tick && hold_cnt != '0;
    advance   = (state == HOLD) && fade_tick && hold_cnt == '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= MODE_OFF;
      johnson  <= '0;
      phase_up <= 1'b1;
      hold_cnt <= '0;
    end else begin
      mode_q <= MODE;
      if (mode_chg) begin
        johnson  <= '0;
        phase_up <= 1'b1;
      end else begin
        if (hold_load) hold_cnt <= HOLD_N;
        else if (hold_dec) hold_cnt <= hold_cnt - 1'b1;
        if (advance && MODE == MODE_RAINBOW) johnson <= johnson_nxt;
        if (advance && MODE == MODE_BREATHE) phase_up <= ~phase_up;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_engine.sv
// Self-checking bench for pwm_fade_engine: level-change
// scoreboard, write table and hand-built corner sequences.
module tb_pwm_fade_engine;

  typedef struct {
    logic [11:0] lv;
    int          gap;
  } exp_t;

  typedef struct {
    int          ch;
    int          data;
    logic [11:0] lv;
  } wr_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [3:0]  wr_data;
  logic [2:0]  pwm_out;
  logic [11:0] level;
  logic        settled;
  logic        period_start;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last   = 0;
  logic mon_en = 1'b0;
  logic [11:0] prev = '0;
  exp_t sbq[$];
  exp_t e;

  pwm_fade_engine #(
    .NUM_CH     (3),
    .PWM_BITS   (4),
    .PWM_DIV    (2),
    .FADE_DIV   (4),
    .FADE_STEP  (5),
    .HOLD_STEPS (1)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .EN           (en),
    .MODE         (mode),
    .WR_EN        (wr_en),
    .WR_CH        (wr_ch),
    .WR_DATA      (wr_data),
    .PWM_OUT      (pwm_out),
    .LEVEL        (level),
    .SETTLED      (settled),
    .PERIOD_START (period_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [11:0] lv, input int gap);
    exp_t x;
    x.lv  = lv;
    x.gap = gap;
    sbq.push_back(x);
  endtask

  function automatic logic [3:0] fstep(input logic [3:0] l,
                                       input logic [3:0] t);
    int li = l;
    int ti = t;
    int n  = li;
    if (li < ti) n = (li + 5 > ti) ? ti : li + 5;
    else if (li > ti) n = (li - 5 < ti) ? ti : li - 5;
    return n[3:0];
  endfunction

  // scoreboard: every change of LEVEL pops one expected record
  always @(negedge clk) begin
    if (mon_en && level !== prev) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL level_unexpected: actual %0h required none",
                 level);
      end else begin
        e = sbq.pop_front();
        chk("level_seq", level, e.lv);
        if (e.gap != 0) chk("level_gap", cyc - last, e.gap);
      end
      last = cyc;
    end
    prev = level;
  end

  task automatic do_reset(input logic [1:0] m);
    rst     = 1'b1;
    en      = 1'b1;
    mode    = m;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write(input int ch, input int data);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_data = data[3:0];
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_level(input logic [11:0] v, input int lim,
                            input string nm);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (level == v) break;
    end
    chk(nm, level, v);
  endtask

  task automatic wait_q(input int lim, input string nm);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    @(negedge clk);
    chk(nm, sbq.size(), 0);
  endtask

  wr_vec_t vec[5];
  logic [3:0] ml[3];
  logic [3:0] mt[3];
  logic [2:0] mj;
  int ps_at;
  int hi0;
  int hi1;
  logic moved;
  logic [3:0] nx;

  initial begin
    vec[0] = '{ch: 1, data: 7,  lv: 12'h07C};
    vec[1] = '{ch: 3, data: 9,  lv: 12'h07C};
    vec[2] = '{ch: 0, data: 2,  lv: 12'h072};
    vec[3] = '{ch: 2, data: 15, lv: 12'hF72};
    vec[4] = '{ch: 1, data: 0,  lv: 12'hF02};

    // reset and rainbow sequence from reset
    do_reset(2'd2);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_level", level, 0);
    chk("rst_settled", settled, 1);
    chk("rst_period_start", period_start, 0);

    for (int c = 0; c < 3; c++) ml[c] = 4'd0;
    mj = 3'b000;
    for (int s = 0; s < 7; s++) begin
      mj = {mj[1:0], ~mj[2]};
      for (int c = 0; c < 3; c++) mt[c] = mj[c] ? 4'd15 : 4'd0;
      for (int g = 0; g < 10; g++) begin
        moved = 1'b0;
        for (int c = 0; c < 3; c++) begin
          nx = fstep(ml[c], mt[c]);
          if (nx != ml[c]) moved = 1'b1;
          ml[c] = nx;
        end
        if (!moved) break;
        push({ml[2], ml[1], ml[0]},
             (g != 0) ? 4 : ((s == 0) ? 0 : 12));
      end
    end

    rst    = 1'b0;
    mon_en = 1'b1;
    ps_at  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (period_start && ps_at < 0) ps_at = k;
      if (k == 33) chk("period_start_pulse", period_start, 0);
    end
    chk("period_start_first", ps_at, 32);
    wait_q(300, "rainbow_drain");
    mon_en = 1'b0;

    // static mode: saturation at 12, then duty
    do_reset(2'd1);
    rst    = 1'b0;
    mon_en = 1'b1;
    push(12'h005, 0);
    push(12'h00A, 4);
    push(12'h00C, 4);
    write(0, 12);
    chk("static_unsettled", settled, 0);
    wait_q(60, "static_drain");
    chk("static_settled", settled, 1);
    mon_en = 1'b0;

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (period_start) break;
    end
    chk("duty_period_seen", period_start, 1);
    hi0 = 0;
    hi1 = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
    end
    chk("duty_ch0", hi0, 24);
    chk("duty_ch1", hi1, 0);

    foreach (vec[i]) begin
      write(vec[i].ch, vec[i].data);
      for (int k = 0; k < 60; k++) begin
        if (settled) break;
        @(negedge clk);
      end
      chk("table_settled", settled, 1);
      chk("table_level", level, vec[i].lv);
    end

    // EN freeze, invalid write while frozen, resume
    write(1, 15);
    wait_level(12'hF52, 20, "en_first_step");
    en = 1'b0;
    @(negedge clk);
    chk("en_pwm_off", pwm_out, 0);
    write(3, 9);
    repeat (15) @(negedge clk);
    chk("en_frozen", level, 12'hF52);
    chk("en_no_period", period_start, 0);
    mon_en = 1'b1;
    push(12'hFA2, 0);
    push(12'hFF2, 4);
    en = 1'b1;
    wait_q(40, "en_resume_drain");
    mon_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("en_final", level, 12'hFF2);

    // breathe with a mid-ramp mode change
    do_reset(2'd0);
    rst = 1'b0;
    write(0, 10);
    write(1, 4);
    write(2, 0);
    @(negedge clk);
    chk("off_settled", settled, 1);
    chk("off_level", level, 0);
    mon_en = 1'b1;
    push(12'h045, 0);
    push(12'h04A, 4);
    push(12'h005, 12);
    mode = 2'd3;
    wait_level(12'h005, 60, "breathe_down");
    push(12'h04A, 4);
    mode = 2'd1;
    @(negedge clk);
    mode = 2'd3;
    wait_level(12'h04A, 20, "breathe_restart");
    @(negedge clk);
    mon_en = 1'b0;
    chk("breathe_drain", sbq.size(), 0);

    // reset in the middle of activity
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_settled", settled, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
